// File: rtl/maze_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : maze_pkg
//  Description : Shared constants, types and corner/address helpers for the
//                maze probe scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
package maze_pkg;

   localparam int MAP_W  = 160;
   localparam int MAP_H  = 120;
   localparam int ADDR_W = 15;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_e;

   typedef logic [1:0] corner_t;

   // Corner walk is (x,y) -> (x+1,y) -> (x+1,y+1) -> (x,y+1)
   function automatic logic corner_dx(input corner_t c);
      return (c == 2'd1) || (c == 2'd2);
   endfunction

   function automatic logic corner_dy(input corner_t c);
      return c[1];
   endfunction

   // Corner coordinates carry one extra bit so x=159+1 / y=119+1 are seen
   function automatic logic corner_off(input logic [8:0] xc, input logic [7:0] yc);
      return (xc >= 9'(MAP_W)) || (yc >= 8'(MAP_H));
   endfunction

   // Off-map corners map to address 0; their verdict is forced to wall
   function automatic logic [ADDR_W-1:0] corner_addr(input logic [8:0] xc, input logic [7:0] yc);
      logic [ADDR_W-1:0] a;
      a = ADDR_W'(xc) + (ADDR_W'(yc) * ADDR_W'(MAP_W));
      return corner_off(xc, yc) ? '0 : a;
   endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin arbiter. Grants the first set
//                request at or after the pointer; pointer state lives in the
//                parent.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
   parameter int N     = 4,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     gnt,
   output logic [IDX_W-1:0] gnt_idx
);

   logic             found;
   logic [IDX_W-1:0] cand;

   // Scan from the pointer upwards with wrap, keep the first hit
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      cand    = '0;
      for (int i = 0; i < N; i++) begin
         cand = IDX_W'((int'(ptr) + i) % N);
         if (!found && req[cand]) begin
            found     = 1'b1;
            gnt[cand] = 1'b1;
            gnt_idx   = cand;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/maze_probe_sched.sv
`default_nettype none
// ============================================================================
//  Module      : maze_probe_sched
//  Description : Shares one single-port maze ROM among NUM_REQ sprite movers.
//                Round-robin arbitration, 2x2 footprint probe (4 ROM reads),
//                registered blocked/win verdict with one-hot done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module maze_probe_sched
   import maze_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ROM_LAT = 1,
   parameter int WIN_X   = 148,
   parameter int WIN_Y   = 110
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NUM_REQ-1:0]   req,
   input  logic [NUM_REQ*8-1:0] req_x,
   input  logic [NUM_REQ*7-1:0] req_y,
   output logic [ADDR_W-1:0]    rom_addr,
   input  logic                 rom_q,
   output logic [NUM_REQ-1:0]   done,
   output logic                 blocked,
   output logic                 win,
   output logic                 busy
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = $clog2(ROM_LAT + 1);

   // FSM and request context
   state_e             state_q, state_d;
   logic [IDX_W-1:0]   ptr_q, ptr_d;
   logic [IDX_W-1:0]   id_q, id_d;
   logic [7:0]         x_q, x_d;
   logic [6:0]         y_q, y_d;
   corner_t            corner_q, corner_d;
   logic [CNT_W-1:0]   drain_q, drain_d;

   // ROM side: address register and a tag pipeline that lines each
   // presented address up with the rom_q it produces ROM_LAT cycles later
   logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
   logic [ROM_LAT:0]   tag_vld_q, tag_vld_d;
   logic [ROM_LAT:0]   tag_off_q, tag_off_d;
   logic               acc_q, acc_d;

   // Verdict outputs
   logic [NUM_REQ-1:0] done_q, done_d;
   logic               blocked_q, blocked_d;
   logic               win_q, win_d;

   // Arbiter and control strobes
   logic [NUM_REQ-1:0] gnt;
   logic [IDX_W-1:0]   gnt_idx;
   logic               any_req;
   logic               accept, issue_step, issue_last, drain_last, busy_w;
   logic [7:0]         sel_x;
   logic [6:0]         sel_y;

   // Address load path
   logic               ld_en, ld_off;
   logic [7:0]         ld_x;
   logic [6:0]         ld_y;
   corner_t            ld_c;
   logic [8:0]         ld_xc;
   logic [7:0]         ld_yc;
   logic [ADDR_W-1:0]  ld_addr;
   logic               sample;

   assign any_req = |req;

   rr_arbiter #(
      .N     (NUM_REQ),
      .IDX_W (IDX_W)
   ) u_arb (
      .req     (req),
      .ptr     (ptr_q),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   // One-hot select of the granted requester's coordinates
   always_comb begin
      sel_x = '0;
      sel_y = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt[i]) begin
            sel_x = req_x[8*i +: 8];
            sel_y = req_y[7*i +: 7];
         end
      end
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (any_req) state_d = ISSUE;
         ISSUE:   if (corner_q == 2'd3) state_d = DRAIN;
         DRAIN:   if (drain_q == CNT_W'(ROM_LAT - 1)) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM output strobes
   always_comb begin
      accept     = (state_q == IDLE) && any_req;
      issue_step = (state_q == ISSUE) && (corner_q != 2'd3);
      issue_last = (state_q == ISSUE) && (corner_q == 2'd3);
      drain_last = (state_q == DRAIN) && (drain_q == CNT_W'(ROM_LAT - 1));
      busy_w     = (state_q == ISSUE) || (state_q == DRAIN);
   end

   // Pick the coordinates/corner whose address is loaded this cycle
   always_comb begin
      ld_en = 1'b0;
      ld_x  = x_q;
      ld_y  = y_q;
      ld_c  = 2'd0;
      if (accept) begin
         ld_en = 1'b1;
         ld_x  = sel_x;
         ld_y  = sel_y;
         ld_c  = 2'd0;
      end else if (issue_step) begin
         ld_en = 1'b1;
         ld_c  = corner_q + 2'd1;
      end
      ld_xc   = {1'b0, ld_x} + {8'd0, corner_dx(ld_c)};
      ld_yc   = {1'b0, ld_y} + {7'd0, corner_dy(ld_c)};
      ld_off  = corner_off(ld_xc, ld_yc);
      ld_addr = corner_addr(ld_xc, ld_yc);
   end

   // Corner verdict arriving this cycle: off-map forces wall
   assign sample = tag_vld_q[ROM_LAT] & (tag_off_q[ROM_LAT] | rom_q);

   // Datapath next values: context latch, address issue, accumulation, verdict
   always_comb begin
      ptr_d      = ptr_q;
      id_d       = id_q;
      x_d        = x_q;
      y_d        = y_q;
      corner_d   = corner_q;
      drain_d    = drain_q;
      acc_d      = acc_q | sample;
      done_d     = '0;
      blocked_d  = blocked_q;
      win_d      = win_q;
      rom_addr_d = ld_en ? ld_addr : rom_addr_q;
      tag_vld_d  = {tag_vld_q[ROM_LAT-1:0], ld_en};
      tag_off_d  = {tag_off_q[ROM_LAT-1:0], ld_en & ld_off};

      if (accept) begin
         id_d     = gnt_idx;
         x_d      = sel_x;
         y_d      = sel_y;
         corner_d = 2'd0;
         acc_d    = 1'b0;
         ptr_d    = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
      end

      if (issue_step) begin
         corner_d = corner_q + 2'd1;
      end

      if (issue_last) begin
         drain_d = '0;
      end else if (state_q == DRAIN) begin
         drain_d = drain_q + CNT_W'(1);
      end

      // Last corner's data is in flight this cycle, so fold it in directly
      if (drain_last) begin
         done_d    = NUM_REQ'(1) << id_q;
         blocked_d = acc_q | sample;
         win_d     = (x_q >= 8'(WIN_X)) && (y_q >= 7'(WIN_Y));
      end
   end

   // Datapath registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr_q      <= '0;
         id_q       <= '0;
         x_q        <= '0;
         y_q        <= '0;
         corner_q   <= 2'd0;
         drain_q    <= '0;
         acc_q      <= 1'b0;
         rom_addr_q <= '0;
         tag_vld_q  <= '0;
         tag_off_q  <= '0;
         done_q     <= '0;
         blocked_q  <= 1'b0;
         win_q      <= 1'b0;
      end else begin
         ptr_q      <= ptr_d;
         id_q       <= id_d;
         x_q        <= x_d;
         y_q        <= y_d;
         corner_q   <= corner_d;
         drain_q    <= drain_d;
         acc_q      <= acc_d;
         rom_addr_q <= rom_addr_d;
         tag_vld_q  <= tag_vld_d;
         tag_off_q  <= tag_off_d;
         done_q     <= done_d;
         blocked_q  <= blocked_d;
         win_q      <= win_d;
      end
   end

   assign rom_addr = rom_addr_q;
   assign done     = done_q;
   assign blocked  = blocked_q;
   assign win      = win_q;
   assign busy     = busy_w;

endmodule
`default_nettype wire

// File: tb/tb_maze_probe_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_maze_probe_sched
//  Description : Self-checking bench for maze_probe_sched with a behavioural
//                ROM and probe model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_maze_probe_sched;

   localparam int NUM_REQ = 4;
   localparam int ROM_LAT = 1;
   localparam int WIN_X   = 148;
   localparam int WIN_Y   = 110;

   logic                 clk = 1'b0;
   logic                 reset;
   logic [NUM_REQ-1:0]   req;
   logic [NUM_REQ*8-1:0] req_x;
   logic [NUM_REQ*7-1:0] req_y;
   logic [14:0]          rom_addr;
   logic                 rom_q = 1'b0;
   logic [NUM_REQ-1:0]   done;
   logic                 blocked;
   logic                 win;
   logic                 busy;

   bit rom_mem [0:32767];

   int checks = 0;
   int errors = 0;

   maze_probe_sched #(
      .NUM_REQ (NUM_REQ),
      .ROM_LAT (ROM_LAT),
      .WIN_X   (WIN_X),
      .WIN_Y   (WIN_Y)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .req      (req),
      .req_x    (req_x),
      .req_y    (req_y),
      .rom_addr (rom_addr),
      .rom_q    (rom_q),
      .done     (done),
      .blocked  (blocked),
      .win      (win),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   // One-cycle-latency ROM
   always @(posedge clk) rom_q <= rom_mem[rom_addr];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic bit m_off(input int x, input int y, input int c);
      int xc, yc;
      xc = x + (((c == 1) || (c == 2)) ? 1 : 0);
      yc = y + ((c >= 2) ? 1 : 0);
      return (xc >= 160) || (yc >= 120);
   endfunction

   function automatic int m_addr(input int x, input int y, input int c);
      int xc, yc;
      xc = x + (((c == 1) || (c == 2)) ? 1 : 0);
      yc = y + ((c >= 2) ? 1 : 0);
      if (m_off(x, y, c)) return 0;
      return xc + 160 * yc;
   endfunction

   function automatic bit m_blocked(input int x, input int y);
      bit b;
      b = 1'b0;
      for (int c = 0; c < 4; c++) begin
         if (m_off(x, y, c) || rom_mem[m_addr(x, y, c)]) b = 1'b1;
      end
      return b;
   endfunction

   function automatic bit m_win(input int x, input int y);
      return (x >= WIN_X) && (y >= WIN_Y);
   endfunction

   task automatic rom_fill(input int density);
      for (int i = 0; i < 32768; i++)
         rom_mem[i] = (density > 0) ? ($urandom_range(0, density - 1) == 0) : 1'b0;
   endtask

   // One isolated request with full cycle-by-cycle checking. With perturb set,
   // the request drops and coordinates change in cycle 2.
   task automatic run_req(input string name, input int id, input int x, input int y, input bit perturb);
      bit exp_blk, exp_win;
      exp_blk = m_blocked(x, y);
      exp_win = m_win(x, y);
      @(negedge clk);
      req = '0;
      req[id] = 1'b1;
      req_x[8*id +: 8] = 8'(x);
      req_y[7*id +: 7] = 7'(y);
      for (int n = 1; n <= 6; n++) begin
         @(negedge clk);
         if (n <= 4) begin
            chk($sformatf("%s addr c%0d", name, n - 1), 32'(rom_addr), 32'(m_addr(x, y, n - 1)));
            chk($sformatf("%s busy c%0d", name, n), 32'(busy), 32'd1);
         end
         if (n < 5 + ROM_LAT) chk($sformatf("%s early done %0d", name, n), 32'(done), 32'd0);
         if (n == 5 + ROM_LAT) begin
            chk($sformatf("%s done", name), 32'(done), 32'(1 << id));
            chk($sformatf("%s blocked", name), 32'(blocked), 32'(exp_blk));
            chk($sformatf("%s win", name), 32'(win), 32'(exp_win));
            chk($sformatf("%s busy at done", name), 32'(busy), 32'd0);
         end
         if (!perturb && n == 1) req = '0;
         if (perturb && n == 2) begin
            req = '0;
            req_x[8*id +: 8] = 8'(x ^ 8'h55);
            req_y[7*id +: 7] = 7'(y ^ 7'h15);
         end
      end
      @(negedge clk);
      chk($sformatf("%s done cleared", name), 32'(done), 32'd0);
      chk($sformatf("%s blocked held", name), 32'(blocked), 32'(exp_blk));
   endtask

   int waited;
   int fx [0:3];
   int fy [0:3];

   initial begin
      reset = 1'b1;
      req   = '0;
      req_x = '0;
      req_y = '0;
      rom_fill(0);
      repeat (2) @(negedge clk);
      chk("reset rom_addr", 32'(rom_addr), 32'd0);
      chk("reset done", 32'(done), 32'd0);
      chk("reset blocked", 32'(blocked), 32'd0);
      chk("reset win", 32'(win), 32'd0);
      chk("reset busy", 32'(busy), 32'd0);
      reset = 1'b0;
      @(negedge clk);

      // Directed cases
      run_req("clear", 0, 10, 10, 1'b0);
      rom_mem[1771] = 1'b1;
      run_req("wall1771", 0, 10, 10, 1'b0);
      rom_mem[1771] = 1'b0;
      rom_mem[1610] = 1'b1;
      run_req("wall1610", 0, 10, 10, 1'b0);
      rom_mem[1610] = 1'b0;
      run_req("edge", 1, 159, 119, 1'b0);
      run_req("winthr", 1, 148, 110, 1'b0);
      run_req("winmiss", 3, 147, 110, 1'b0);

      // Randomized probes against the model
      rom_fill(8);
      for (int k = 0; k < 12; k++) begin
         int rx, ry, rid;
         rid = $urandom_range(0, NUM_REQ - 1);
         rx  = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 255) : $urandom_range(140, 165);
         ry  = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 127) : $urandom_range(105, 125);
         run_req($sformatf("rand%0d", k), rid, rx, ry, 1'b0);
      end

      // Fairness: all requests held from reset
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < NUM_REQ; i++) begin
         fx[i] = $urandom_range(0, 158);
         fy[i] = $urandom_range(0, 118);
         req_x[8*i +: 8] = 8'(fx[i]);
         req_y[7*i +: 7] = 7'(fy[i]);
      end
      req = '1;
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < 5; k++) begin
         waited = 0;
         do begin
            @(negedge clk);
            waited++;
         end while (done == '0 && waited < 20);
         chk($sformatf("fair order %0d", k), 32'(done), 32'(1 << (k % 4)));
         chk($sformatf("fair gap %0d", k), 32'(waited), 32'((k == 0) ? (5 + ROM_LAT) : (6 + ROM_LAT)));
         chk($sformatf("fair blocked %0d", k), 32'(blocked), 32'(m_blocked(fx[k % 4], fy[k % 4])));
         chk($sformatf("fair win %0d", k), 32'(win), 32'(m_win(fx[k % 4], fy[k % 4])));
      end
      req = '0;
      repeat (3) @(negedge clk);

      // Leave the pointer at 3, with a set blocked/win verdict on the outputs
      run_req("preset", 2, 159, 119, 1'b0);

      // Reset in cycle 3 of a request to 2; req3 also pending
      req_x[8*2 +: 8] = 8'd30;  req_y[7*2 +: 7] = 7'd40;
      req_x[8*3 +: 8] = 8'd90;  req_y[7*3 +: 7] = 7'd50;
      @(negedge clk);
      req = 4'b0100;
      @(negedge clk);
      req = 4'b1100;
      chk("midrst busy", 32'(busy), 32'd1);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("midrst rom_addr", 32'(rom_addr), 32'd0);
      chk("midrst done", 32'(done), 32'd0);
      chk("midrst blocked", 32'(blocked), 32'd0);
      chk("midrst win", 32'(win), 32'd0);
      chk("midrst busy0", 32'(busy), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      for (int n = 1; n <= 5 + ROM_LAT; n++) begin
         @(negedge clk);
         if (n <= 4) chk($sformatf("postrst addr c%0d", n - 1), 32'(rom_addr), 32'(m_addr(30, 40, n - 1)));
         if (n < 5 + ROM_LAT) chk($sformatf("postrst no done %0d", n), 32'(done), 32'd0);
      end
      chk("postrst grant req2", 32'(done), 32'b0100);
      chk("postrst blocked", 32'(blocked), 32'(m_blocked(30, 40)));
      req = '0;
      repeat (3) @(negedge clk);

      // Request change during service
      rom_fill(0);
      rom_mem[21 + 160 * 30] = 1'b1;
      run_req("perturb", 0, 20, 30, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Absolute time limit so the run always terminates
   initial begin
      #500000;
      errors++;
      $display("FAIL timeout: observed no finish, required finish");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
